// File: rtl/motor_pkg.sv
// Shared encodings, channel state type and command payload for the dual H-bridge PWM driver.
package motor_pkg;

  localparam int unsigned DUTY_W = 12;

  // Bridge input pair encodings
  localparam logic [1:0] COAST = 2'b00;
  localparam logic [1:0] DRV_P = 2'b01;
  localparam logic [1:0] DRV_N = 2'b10;

  // Movement codes from the line-following controller ({pair A, pair B})
  localparam logic [3:0] FWD   = 4'b0110;
  localparam logic [3:0] BWD   = 4'b1001;
  localparam logic [3:0] LEFT  = 4'b0101;
  localparam logic [3:0] RIGHT = 4'b1010;
  localparam logic [3:0] STOP  = 4'b0000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DEAD = 2'd2
  } ch_state_e;

  typedef struct packed {
    logic [1:0]        pair;
    logic [DUTY_W-1:0] duty;
  } ch_cmd_t;

  // Both bridge inputs high would short the supply; treat it as coast.
  function automatic logic [1:0] sanitize_pair(input logic [1:0] p);
    return (p == 2'b11) ? COAST : p;
  endfunction

endpackage

// File: rtl/motor_channel.sv
// One H-bridge channel: direction FSM with dead time, applied duty and PWM compare.
// Define MOTOR_PWM_RAMP_EN to ramp the applied duty toward the target by RAMP_STEP per period.
module motor_channel
  import motor_pkg::*;
#(
  parameter int unsigned PERIOD       = 4096,
  parameter int unsigned DEAD_PERIODS = 2,
  parameter int unsigned RAMP_STEP    = 256,
  parameter int unsigned CNT_W        = $clog2(PERIOD)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             boundary,
  input  logic [CNT_W-1:0] cnt,
  input  ch_cmd_t          cmd,
  output logic             pwm,
  output logic [1:0]       in_pair,
  output logic             dead
);

  localparam int unsigned DEAD_W = $clog2(DEAD_PERIODS + 1);

`ifdef MOTOR_PWM_RAMP_EN
  localparam bit RAMP_EN = 1'b1;
`else
  localparam bit RAMP_EN = 1'b0;
`endif

  ch_state_e         state;
  logic [1:0]        tgt_pair;
  logic [DUTY_W-1:0] duty;
  logic [DEAD_W-1:0] dead_cnt;

  logic [1:0]        req_pair;
  logic [DUTY_W-1:0] run_duty;
  logic [DUTY_W-1:0] entry_duty;

  function automatic logic pwm_on(input logic [CNT_W-1:0] c, input logic [DUTY_W-1:0] d);
    return (32'(d) >= PERIOD) || (32'(c) < 32'(d));
  endfunction

  // Rising duty climbs by RAMP_STEP and saturates at target; falling duty snaps to target.
  function automatic logic [DUTY_W-1:0] ramp_toward(input logic [DUTY_W-1:0] cur,
                                                    input logic [DUTY_W-1:0] tgt);
    logic [31:0] sum;
    sum = 32'(cur) + 32'(RAMP_STEP);
    if ((tgt <= cur) || (sum >= 32'(tgt))) return tgt;
    return DUTY_W'(sum);
  endfunction

  always_comb begin
    req_pair   = sanitize_pair(cmd.pair);
    run_duty   = RAMP_EN ? ramp_toward(duty, cmd.duty) : cmd.duty;
    entry_duty = RAMP_EN ? ramp_toward(DUTY_W'(0), cmd.duty) : cmd.duty;
  end

  // Commands are acted on only at the period boundary; pwm is the registered compare.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      tgt_pair <= COAST;
      in_pair  <= COAST;
      duty     <= '0;
      dead_cnt <= '0;
      pwm      <= 1'b0;
      dead     <= 1'b0;
    end else if (boundary) begin
      pwm <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req_pair != COAST) begin
            state    <= ST_DEAD;
            tgt_pair <= req_pair;
            dead_cnt <= DEAD_W'(DEAD_PERIODS);
            dead     <= 1'b1;
          end
        end
        ST_RUN: begin
          if (req_pair == in_pair) begin
            duty <= run_duty;
            pwm  <= pwm_on(cnt, run_duty);
          end else if (req_pair == COAST) begin
            state   <= ST_IDLE;
            in_pair <= COAST;
            duty    <= '0;
          end else begin
            state    <= ST_DEAD;
            tgt_pair <= req_pair;
            in_pair  <= COAST;
            duty     <= '0;
            dead_cnt <= DEAD_W'(DEAD_PERIODS);
            dead     <= 1'b1;
          end
        end
        ST_DEAD: begin
          if (req_pair == COAST) begin
            state    <= ST_IDLE;
            dead_cnt <= '0;
            dead     <= 1'b0;
          end else if (req_pair != tgt_pair) begin
            tgt_pair <= req_pair;
            dead_cnt <= DEAD_W'(DEAD_PERIODS);
          end else if (dead_cnt <= DEAD_W'(1)) begin
            state    <= ST_RUN;
            in_pair  <= tgt_pair;
            duty     <= entry_duty;
            pwm      <= pwm_on(cnt, entry_duty);
            dead_cnt <= '0;
            dead     <= 1'b0;
          end else begin
            dead_cnt <= dead_cnt - DEAD_W'(1);
          end
        end
        default: begin
          state    <= ST_IDLE;
          in_pair  <= COAST;
          duty     <= '0;
          dead_cnt <= '0;
          dead     <= 1'b0;
        end
      endcase
    end else begin
      pwm <= (state == ST_RUN) && pwm_on(cnt, duty);
    end
  end

endmodule

// File: rtl/motor_pwm_driver.sv
// Dual-channel H-bridge PWM driver: shared period counter feeding two dead-time protected channels.
// Duty ramping is enabled by defining MOTOR_PWM_RAMP_EN (see motor_channel).
module motor_pwm_driver
  import motor_pkg::*;
#(
  parameter int unsigned PERIOD       = 4096,
  parameter int unsigned DEAD_PERIODS = 2,
  parameter int unsigned RAMP_STEP    = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [3:0]        Direction,
  input  logic [DUTY_W-1:0] DutyA,
  input  logic [DUTY_W-1:0] DutyB,
  output logic              pwm_a,
  output logic              pwm_b,
  output logic [1:0]        in_a,
  output logic [1:0]        in_b,
  output logic              dead_a,
  output logic              dead_b
);

  localparam int unsigned CNT_W = $clog2(PERIOD);

  logic [CNT_W-1:0] cnt;
  logic             boundary_c;
  ch_cmd_t          cmd_a;
  ch_cmd_t          cmd_b;

  assign boundary_c = (cnt == CNT_W'(PERIOD - 1));
  assign cmd_a      = '{pair: Direction[3:2], duty: DutyA};
  assign cmd_b      = '{pair: Direction[1:0], duty: DutyB};

  // Free-running period counter shared by both channels
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (boundary_c) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  motor_channel #(
    .PERIOD       (PERIOD),
    .DEAD_PERIODS (DEAD_PERIODS),
    .RAMP_STEP    (RAMP_STEP),
    .CNT_W        (CNT_W)
  ) u_ch_a (
    .clk      (clk),
    .rst_n    (rst_n),
    .boundary (boundary_c),
    .cnt      (cnt),
    .cmd      (cmd_a),
    .pwm      (pwm_a),
    .in_pair  (in_a),
    .dead     (dead_a)
  );

  motor_channel #(
    .PERIOD       (PERIOD),
    .DEAD_PERIODS (DEAD_PERIODS),
    .RAMP_STEP    (RAMP_STEP),
    .CNT_W        (CNT_W)
  ) u_ch_b (
    .clk      (clk),
    .rst_n    (rst_n),
    .boundary (boundary_c),
    .cnt      (cnt),
    .cmd      (cmd_b),
    .pwm      (pwm_b),
    .in_pair  (in_b),
    .dead     (dead_b)
  );

endmodule

// File: doc/motor_pwm_driver.md
# motor_pwm_driver

Dual-channel H-bridge driver sitting directly downstream of the line-following movement controller. Consumes its 4-bit `Direction` code and the 12-bit `DutyA`/`DutyB` words, and produces glitch-free PWM enables plus bridge input pairs for motors A and B. Updates occur only at PWM period boundaries. A dead-time interval is enforced on every direction change so that neither bridge is ever shoot-through-switched.

## Interface
- `PERIOD`, 4096: PWM period in clk cycles; counter width is `$clog2(PERIOD)`.
- `DEAD_PERIODS`, 2: full PWM periods with the bridge forced off on a channel direction change (≥1).
- `RAMP_STEP`, 256: duty increment per period when ramping is compiled in.
- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `Direction`  in  4  [3:2] is motor A pair, [1:0] is motor B pair; 01/10 drive, 00 coast, 11 illegal.
- `DutyA`, `DutyB`  in  12 each  requested high-count per period.
- `pwm_a`, `pwm_b`  out  1 each  bridge enable PWM.
- `in_a`, `in_b`  out  2 each  bridge input pairs (applied direction).
- `dead_a`, `dead_b`  out  1 each  channel currently in dead time.

## Operation
- A free-running counter runs from 0 to PERIOD-1 and wraps. The boundary is the cycle where cnt==PERIOD-1.
- The inputs are sampled only at the boundary. Mid-period input changes are ignored until the next boundary.
- A pair value of 11 is treated as 00 at sampling.
- Each channel has a 3-state FSM: IDLE, RUN, DEAD.
  - IDLE (applied pair 00): if the sampled pair is nonzero, enter DEAD and load the dead counter with DEAD_PERIODS.
  - RUN: if the sampled pair equals the applied pair, update the duty only. If the sampled pair is 00, go to IDLE immediately (in=00, duty=0) with no dead time. If the sampled pair is the other nonzero value, enter DEAD.
  - DEAD: in=00 and pwm=0. The dead counter decrements at each boundary. When the counter reaches 0 at a boundary, apply the target pair and duty and go to RUN.
  - A new differing target while in DEAD updates the target and reloads the dead counter.
  - A target of 00 while in DEAD goes to IDLE.
- PWM rule: pwm = (cnt < duty_applied). If duty_applied ≥ PERIOD, pwm is constant 1. If duty is 0, pwm is constant 0.
- All outputs are registered.

## Timing
- Reset value of every output and all state is 0. Reset is asynchronous and immediate, and is valid mid-period. The counter restarts at 0 after reset.
- Input sampled at boundary cycle t: new `in_x`/duty are visible from cycle t+1 (cnt=0). `pwm_x` lags cnt by 1 cycle.
- Reversal latency: DEAD_PERIODS×PERIOD cycles of in=00, then the new pair is applied.
- `in_x` and `pwm_x` change in the same cycle. `in_x` never transitions directly between 01 and 10.

## Configuration
- `MOTOR_PWM_RAMP_EN` defined:
  - In RUN, duty_applied moves toward the target by at most RAMP_STEP per boundary, saturating at the target.
  - Entry to RUN from DEAD starts from 0.
  - A decrease toward a lower target is immediate.
- `MOTOR_PWM_RAMP_EN` undefined: duty_applied equals the target at each boundary.

## Structure
- Shared package `motor_pkg`:
  - pair encodings COAST=2'b00, DRV_P=2'b01, DRV_N=2'b10.
  - channel state typedef (IDLE/RUN/DEAD).
  - the movement codes FWD=4'b0110, BWD=4'b1001, LEFT=4'b0101, RIGHT=4'b1010, STOP=4'b0000.
- Sub-module `motor_channel`: FSM, dead counter, duty/ramp register, and PWM compare for one motor. It is instantiated twice.
- The top level owns the shared period counter and the boundary strobe.

## Test plan
- Reset asserted mid-period with Direction=0110, Duty=4000: all outputs are 0 immediately. After release, `in_a`/`in_b` are 00 until dead time completes.
- Direction=0110, DutyA=DutyB=4000 held (no ramp):
  - after 2 dead periods, in_a=01 and in_b=10.
  - pwm high exactly 4000 of every 4096 cycles.
- FWD→BWD at a boundary: in_a/in_b=00 and pwm=0 for exactly 8192 cycles, then in_a=10 and in_b=01. dead_a/dead_b are high throughout.
- RUN FWD, DutyA changed 4000→1000 at cnt=100: the current period still runs 4000 high, and the next period runs 1000.
- Direction=1101 (A illegal): channel A goes to IDLE immediately with in_a=00 and pwm_a=0, while channel B is unaffected.
- With `MOTOR_PWM_RAMP_EN`, DutyA=1000 after dead time: high counts are 256, 512, 768, then 1000 held.
